// File: rtl/nn_fixed_pkg.sv
// Shared fixed-point formats, saturation limits and FSM encoding for the neuron datapath.
// The round_sat_f function mirrors the round_sat module at the default formats.
package nn_fixed_pkg;

    localparam int unsigned X_F   = 5;
    localparam int unsigned W_F   = 6;
    localparam int unsigned W_OUT = 8;
    localparam int unsigned OUT_I = 3;
    localparam int unsigned OUT_F = W_OUT - OUT_I;
    localparam int unsigned SHIFT = X_F + W_F - OUT_F;
    localparam int unsigned ACC_W = 24;

    localparam logic signed [W_OUT-1:0] OUT_MAX = 8'sd127;
    localparam logic signed [W_OUT-1:0] OUT_MIN = -8'sd127;

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_ROUND  = 2'd2,
        ST_RESULT = 2'd3
    } state_e;

    typedef struct packed {
        logic             sat;
        logic [W_OUT-1:0] data;
    } rs_t;

    // Round-half-up then clip symmetrically so the negating consumer never sees -2^(W_OUT-1).
    function automatic rs_t round_sat_f(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W:0] sum;
        logic signed [ACC_W:0] shr;
        rs_t res;
        sum = {acc[ACC_W-1], acc} + (ACC_W+1)'(1 << (SHIFT - 1));
        shr = sum >>> SHIFT;
        res.sat  = 1'b0;
        res.data = shr[W_OUT-1:0];
        if (shr > (ACC_W+1)'(OUT_MAX)) begin
            res.sat  = 1'b1;
            res.data = OUT_MAX;
        end else if (shr < (ACC_W+1)'(OUT_MIN)) begin
            res.sat  = 1'b1;
            res.data = OUT_MIN;
        end
        return res;
    endfunction

endpackage

// File: rtl/round_sat.sv
// Combinational round-half-up and symmetric saturation of an accumulator into W_OUT bits.
module round_sat #(
    parameter int unsigned ACC_W = 24,
    parameter int unsigned W_OUT = 8,
    parameter int unsigned SHIFT = 6
) (
    input  logic signed [ACC_W-1:0] i_acc,
    output logic        [W_OUT-1:0] o_data,
    output logic                    o_sat
);

    localparam logic signed [ACC_W:0] ONE   = {{ACC_W{1'b0}}, 1'b1};
    localparam logic signed [ACC_W:0] HALF  = ONE << (SHIFT - 1);
    localparam logic signed [ACC_W:0] LIM_P = (ONE << (W_OUT - 1)) - ONE;
    localparam logic signed [ACC_W:0] LIM_N = -LIM_P;

    // One guard bit so adding the half-LSB cannot wrap at the top of the range.
    logic signed [ACC_W:0] w_sum;
    logic signed [ACC_W:0] w_shr;

    assign w_sum = {i_acc[ACC_W-1], i_acc} + HALF;
    assign w_shr = w_sum >>> SHIFT;

    always_comb begin
        o_sat  = 1'b0;
        o_data = w_shr[W_OUT-1:0];
        if (w_shr > LIM_P) begin
            o_sat  = 1'b1;
            o_data = LIM_P[W_OUT-1:0];
        end else if (w_shr < LIM_N) begin
            o_sat  = 1'b1;
            o_data = LIM_N[W_OUT-1:0];
        end
    end

endmodule

// File: rtl/neuron_mac.sv
// Streaming MAC neuron: product stage, bias-seeded accumulator, then round/saturate into
// the activation stage's fixed-point input, presented on a valid/ready output.
module neuron_mac #(
    parameter int unsigned W_X     = 8,
    parameter int unsigned X_F     = 5,
    parameter int unsigned W_W     = 8,
    parameter int unsigned W_F     = 6,
    parameter int unsigned W_OUT   = 8,
    parameter int unsigned OUT_I   = 3,
    parameter int unsigned MAX_LEN = 32,
    parameter int unsigned ACC_W   = 24
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [W_X-1:0]   in_x,
    input  logic signed [W_W-1:0]   in_w,
    input  logic                    in_last,
    input  logic signed [W_OUT-1:0] in_bias,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic        [W_OUT-1:0] out_data,
    output logic                    out_sat,
    output logic                    out_len_err
);

    import nn_fixed_pkg::*;

    localparam int unsigned OUT_F = W_OUT - OUT_I;
    localparam int unsigned SHIFT = X_F + W_F - OUT_F;
    localparam int unsigned P_W   = W_X + W_W;
    localparam int unsigned CNT_W = $clog2(MAX_LEN + 1);

    state_e                   r_state;
    logic [CNT_W-1:0]         r_cnt;
    logic                     r_len_err;
    logic signed [P_W-1:0]    r_p;
    logic                     r_p_valid;
    logic                     r_p_first;
    logic signed [W_OUT-1:0]  r_p_bias;
    logic signed [ACC_W-1:0]  r_acc;

    logic                     w_accept;
    logic                     w_full;
    logic signed [ACC_W-1:0]  w_p_ext;
    logic signed [ACC_W-1:0]  w_bias_ext;
    logic signed [ACC_W-1:0]  w_acc_base;
    logic [W_OUT-1:0]         w_rs_data;
    logic                     w_rs_sat;

    assign in_ready   = (r_state == ST_ACCUM);
    assign w_accept   = in_valid & in_ready;
    assign w_full     = (r_cnt == CNT_W'(MAX_LEN - 1));
    assign w_p_ext    = {{(ACC_W-P_W){r_p[P_W-1]}}, r_p};
    assign w_bias_ext = {{(ACC_W-W_OUT){r_p_bias[W_OUT-1]}}, r_p_bias} <<< SHIFT;
    // The first product of a packet replaces the old sum with the aligned bias.
    assign w_acc_base = r_p_first ? w_bias_ext : r_acc;

    round_sat #(
        .ACC_W (ACC_W),
        .W_OUT (W_OUT),
        .SHIFT (SHIFT)
    ) u_round_sat (
        .i_acc  (r_acc),
        .o_data (w_rs_data),
        .o_sat  (w_rs_sat)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_p       <= '0;
            r_p_valid <= 1'b0;
            r_p_first <= 1'b0;
            r_p_bias  <= '0;
            r_acc     <= '0;
        end else begin
            r_p_valid <= w_accept;
            if (w_accept) begin
                r_p       <= in_x * in_w;
                r_p_first <= (r_cnt == '0);
                r_p_bias  <= in_bias;
            end
            if (r_p_valid) begin
                r_acc <= w_acc_base + w_p_ext;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_ACCUM;
            r_cnt       <= '0;
            r_len_err   <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_sat     <= 1'b0;
            out_len_err <= 1'b0;
        end else begin
            unique case (r_state)
                ST_ACCUM: begin
                    if (w_accept) begin
                        if (in_last || w_full) begin
                            r_cnt     <= '0;
                            r_len_err <= ~in_last;
                            r_state   <= ST_FLUSH;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    r_state <= ST_ROUND;
                end
                ST_ROUND: begin
                    out_data    <= w_rs_data;
                    out_sat     <= w_rs_sat;
                    out_len_err <= r_len_err;
                    out_valid   <= 1'b1;
                    r_state     <= ST_RESULT;
                end
                ST_RESULT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= ST_ACCUM;
                    end
                end
                default: r_state <= ST_ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac with hand-computed Q3.5 results.
module tb_neuron_mac;

    logic              clock;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] in_x;
    logic signed [7:0] in_w;
    logic              in_last;
    logic signed [7:0] in_bias;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_data;
    logic              out_sat;
    logic              out_len_err;

    int n_vec = 0;
    int n_err = 0;

    neuron_mac dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_x        (in_x),
        .in_w        (in_w),
        .in_last     (in_last),
        .in_bias     (in_bias),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_sat     (out_sat),
        .out_len_err (out_len_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives one beat and returns #1 after the edge that accepted it.
    task automatic send_beat(input logic signed [7:0] x, input logic signed [7:0] w,
                             input logic signed [7:0] b, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_x     = x;
        in_w     = w;
        in_bias  = b;
        in_last  = last;
        while (!in_ready && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL beat_accept: in_ready got 0 required 1");
        end
        @(posedge clock); #1;
    endtask

    // Non-first beats carry a scrambled bias that must be ignored.
    task automatic send_pkt(input int n, input logic signed [7:0] x, input logic signed [7:0] w,
                            input logic signed [7:0] b, input logic term);
        for (int i = 0; i < n; i++) begin
            send_beat(x, w, (i == 0) ? b : ~b, term && (i == n - 1));
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic collect(output logic [7:0] d, output logic s, output logic e,
                           output logic ok);
        int n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        ok = out_valid;
        d  = out_data;
        s  = out_sat;
        e  = out_len_err;
        if (ok) begin
            out_ready = 1'b1;
            @(posedge clock); #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        n_vec++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sat !== 1'b0
            || out_len_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got v=%b d=%h s=%b e=%b required 0 00 0 0",
                     out_valid, out_data, out_sat, out_len_err);
        end
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
    endtask

    task automatic test_single();
        logic [7:0] d;
        logic s, e, ok;
        send_pkt(1, 8'sd32, 8'sd64, 8'sd0, 1'b1);
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL latency_c1: got v=%b rdy=%b required 0 0", out_valid, in_ready);
        end
        @(posedge clock); #1;
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL latency_c2: out_valid got %b required 0", out_valid);
        end
        @(posedge clock); #1;
        n_vec++;
        if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL latency_c3: out_valid got %b required 1", out_valid);
        end
        collect(d, s, e, ok);
        n_vec++;
        if (!ok || d !== 8'd32 || s !== 1'b0 || e !== 1'b0) begin
            n_err++;
            $display("FAIL single_b0: got ok=%b d=%h s=%b e=%b required 1 20 0 0", ok, d, s, e);
        end
        send_pkt(1, 8'sd32, 8'sd64, -8'sd16, 1'b1);
        collect(d, s, e, ok);
        n_vec++;
        if (!ok || d !== 8'd16 || s !== 1'b0) begin
            n_err++;
            $display("FAIL single_bneg: got ok=%b d=%h s=%b required 1 10 0", ok, d, s);
        end
    endtask

    task automatic test_multi();
        logic [7:0] d;
        logic s, e, ok;
        send_pkt(4, 8'sd32, 8'sd32, 8'sd8, 1'b1);
        collect(d, s, e, ok);
        n_vec++;
        if (!ok || d !== 8'd72 || s !== 1'b0 || e !== 1'b0) begin
            n_err++;
            $display("FAIL multi_4beat: got ok=%b d=%h s=%b e=%b required 1 48 0 0", ok, d, s, e);
        end
    endtask

    task automatic test_rounding();
        logic signed [7:0] xs [4] = '{8'sd1, 8'sd1, -8'sd1, -8'sd1};
        logic signed [7:0] ws [4] = '{8'sd32, 8'sd31, 8'sd32, 8'sd33};
        logic [7:0]        es [4] = '{8'h01, 8'h00, 8'h00, 8'hFF};
        logic [7:0] d;
        logic s, e, ok;
        for (int i = 0; i < 4; i++) begin
            send_pkt(1, xs[i], ws[i], 8'sd0, 1'b1);
            collect(d, s, e, ok);
            n_vec++;
            if (!ok || d !== es[i] || s !== 1'b0) begin
                n_err++;
                $display("FAIL round_%0d: got ok=%b d=%h s=%b required 1 %h 0", i, ok, d, s, es[i]);
            end
        end
    endtask

    task automatic test_saturation();
        logic [7:0] d;
        logic s, e, ok;
        send_pkt(16, 8'sd127, 8'sd127, 8'sd0, 1'b1);
        collect(d, s, e, ok);
        n_vec++;
        if (!ok || d !== 8'h7F || s !== 1'b1) begin
            n_err++;
            $display("FAIL sat_pos: got ok=%b d=%h s=%b required 1 7f 1", ok, d, s);
        end
        send_pkt(16, -8'sd128, 8'sd127, 8'sd0, 1'b1);
        collect(d, s, e, ok);
        n_vec++;
        if (!ok || d !== 8'h81 || s !== 1'b1) begin
            n_err++;
            $display("FAIL sat_neg: got ok=%b d=%h s=%b required 1 81 1", ok, d, s);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        logic s, e, ok;
        int n = 0;
        send_pkt(1, 8'sd32, 8'sd64, 8'sd0, 1'b1);
        while (!out_valid && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (out_valid !== 1'b1 || out_data !== 8'd32 || out_sat !== 1'b0
                || out_len_err !== 1'b0 || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL hold_%0d: got v=%b d=%h s=%b e=%b rdy=%b required 1 20 0 0 0",
                         i, out_valid, out_data, out_sat, out_len_err, in_ready);
            end
            @(posedge clock); #1;
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL release: got v=%b rdy=%b required 0 1", out_valid, in_ready);
        end
        send_pkt(1, 8'sd32, 8'sd64, 8'sd32, 1'b1);
        collect(d, s, e, ok);
        n_vec++;
        if (!ok || d !== 8'd64 || s !== 1'b0) begin
            n_err++;
            $display("FAIL back_to_back: got ok=%b d=%h s=%b required 1 40 0", ok, d, s);
        end
    endtask

    task automatic test_length();
        logic [7:0] d;
        logic s, e, ok;
        send_pkt(32, 8'sd32, 8'sd2, 8'sd0, 1'b0);
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL len_stop: in_ready got %b required 0", in_ready);
        end
        collect(d, s, e, ok);
        n_vec++;
        if (!ok || d !== 8'd32 || e !== 1'b1) begin
            n_err++;
            $display("FAIL len_force: got ok=%b d=%h e=%b required 1 20 1", ok, d, e);
        end
        send_pkt(1, 8'sd32, 8'sd64, -8'sd16, 1'b1);
        collect(d, s, e, ok);
        n_vec++;
        if (!ok || d !== 8'd16 || e !== 1'b0) begin
            n_err++;
            $display("FAIL len_beat33: got ok=%b d=%h e=%b required 1 10 0", ok, d, e);
        end
        send_pkt(32, 8'sd32, 8'sd2, 8'sd0, 1'b1);
        collect(d, s, e, ok);
        n_vec++;
        if (!ok || d !== 8'd32 || e !== 1'b0) begin
            n_err++;
            $display("FAIL len_exact: got ok=%b d=%h e=%b required 1 20 0", ok, d, e);
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] d;
        logic s, e, ok;
        send_pkt(3, 8'sd127, 8'sd127, 8'sd100, 1'b0);
        reset = 1'b1;
        #1;
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset_valid: got %b required 0", out_valid);
        end
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset_ready: got rdy=%b v=%b required 1 0", in_ready, out_valid);
        end
        send_pkt(1, 8'sd1, 8'sd32, 8'sd0, 1'b1);
        collect(d, s, e, ok);
        n_vec++;
        if (!ok || d !== 8'd1 || s !== 1'b0 || e !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset_next: got ok=%b d=%h s=%b e=%b required 1 01 0 0",
                     ok, d, s, e);
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_x      = '0;
        in_w      = '0;
        in_last   = 1'b0;
        in_bias   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        test_reset();
        test_single();
        test_multi();
        test_rounding();
        test_saturation();
        test_back_to_back();
        test_length();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
